// File: rtl/down_timer_if.sv
// Handshake-free control bundle for down_timer.
// master drives load/load_val/start/pause; slave returns q/busy/done.
interface down_timer_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             start;
    logic             pause;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;

    modport master (
        output load, load_val, start, pause,
        input  q, busy, done
    );

    modport slave (
        input  load, load_val, start, pause,
        output q, busy, done
    );
endinterface

// File: rtl/down_timer.sv
// Loadable down counter with IDLE/RUN/HOLD/DONE control FSM.
// Ports: clock, reset (async active-low), bus (down_timer_if.slave):
//   load/load_val load the count, start begins, pause freezes;
//   q = count, busy = counting, done = one-cycle terminal pulse.
// Option: DOWN_TIMER_AUTO_RELOAD_EN restarts from the loaded value.
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    down_timer_if.slave  bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HOLD,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nx;

`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] rld;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rld <= '0;
        end else if (bus.load) begin
            rld <= bus.load_val;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (bus.load) begin
            cnt_nx   = bus.load_val;
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start && cnt != '0) begin
                        state_nx = RUN;
                    end
                end
                RUN: begin
                    if (bus.pause) begin
                        state_nx = HOLD;
                    end else if (cnt <= ONE) begin
                        // <= also covers 0 so q can never wrap
                        cnt_nx   = '0;
                        state_nx = DONE;
                    end else begin
                        cnt_nx = cnt - ONE;
                    end
                end
                HOLD: begin
                    if (!bus.pause) begin
                        state_nx = RUN;
                    end
                end
                DONE: begin
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
                    if (rld != '0) begin
                        cnt_nx   = rld;
                        state_nx = RUN;
                    end else begin
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end
`else
                    cnt_nx   = '0;
                    state_nx = IDLE;
`endif
                end
                default: begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end
            endcase
        end
    end

    assign bus.q    = cnt;
    assign bus.done = (state == DONE);
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    // A reloading DONE cycle is still part of an active run
    assign bus.busy = (state == RUN) || (state == HOLD)
                   || ((state == DONE) && (rld != '0));
`else
    assign bus.busy = (state == RUN) || (state == HOLD);
`endif
endmodule

// File: tb/tb_down_timer.sv
// Scoreboarded random/directed bench for down_timer.
// Expected q/busy/done come from a behavioural model in this file.
module tb_down_timer;
    localparam int W = 4;
`ifdef DOWN_TIMER_AUTO_RELOAD_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    typedef struct {
        int q;
        int busy;
        int done;
    } exp_t;

    logic clock;
    logic reset;
    bit   rn;
    int   n_chk;
    int   n_err;
    exp_t sb[$];

    down_timer_if #(.WIDTH(W)) bus ();

    down_timer #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: remaining count, whether a countdown is in progress,
    // whether it is frozen, and whether this is the terminal cycle.
    int m_q;
    int m_rl;
    bit m_cnt;
    bit m_frz;
    bit m_pls;

    function automatic void m_reset();
        m_q   = 0;
        m_rl  = 0;
        m_cnt = 0;
        m_frz = 0;
        m_pls = 0;
    endfunction

    function automatic void m_step(bit ld, int lv, bit st, bit pa);
        if (ld) begin
            m_q   = lv;
            m_rl  = lv;
            m_cnt = 0;
            m_frz = 0;
            m_pls = 0;
            return;
        end
        if (m_pls) begin
            m_pls = 0;
            if (AUTO && m_rl != 0) begin
                m_q   = m_rl;
                m_cnt = 1;
                m_frz = 0;
            end else begin
                m_q = 0;
            end
            return;
        end
        if (m_cnt) begin
            if (m_frz) begin
                m_frz = pa;
            end else if (pa) begin
                m_frz = 1;
            end else begin
                m_q = m_q - 1;
                if (m_q == 0) begin
                    m_cnt = 0;
                    m_pls = 1;
                end
            end
            return;
        end
        if (st && m_q != 0) begin
            m_cnt = 1;
            m_frz = 0;
        end
    endfunction

    function automatic exp_t m_out();
        exp_t e;
        e.q    = m_q;
        e.busy = (m_cnt || (m_pls && AUTO && m_rl != 0)) ? 1 : 0;
        e.done = m_pls ? 1 : 0;
        return e;
    endfunction

    function automatic void chk(string nm, logic [31:0] act,
                                logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    task automatic cyc(bit ld, int lv, bit st, bit pa);
        @(negedge clock);
        reset        = rn;
        bus.load     = ld;
        bus.load_val = W'(lv);
        bus.start    = st;
        bus.pause    = pa;
        if (!rn) m_reset();
        else m_step(ld, lv, st, pa);
        sb.push_back(m_out());
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0);
    endtask

    // Run until the model count reaches v (bounded)
    task automatic run_to(int v);
        for (int i = 0; i < 40 && m_q != v; i++) cyc(0, 0, 0, 0);
    endtask

    // Assert reset between edges and check outputs clear at once
    task automatic async_rst();
        @(posedge clock);
        #3;
        reset = 1'b0;
        rn    = 1'b0;
        m_reset();
        #1;
        chk("async_q", bus.q, 0);
        chk("async_busy", bus.busy, 0);
        chk("async_done", bus.done, 0);
    endtask

    // Monitor: every cycle the DUT presents a fresh result
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("q", bus.q, e.q);
                chk("busy", bus.busy, e.busy);
                chk("done", bus.done, e.done);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_chk        = 0;
        n_err        = 0;
        reset        = 1'b0;
        rn           = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;
        bus.start    = 1'b0;
        bus.pause    = 1'b0;
        m_reset();

        // reset dominates a load
        cyc(1, 9, 1, 0);
        idle(2);
        rn = 1'b1;
        idle(2);

        // basic countdown from 5
        cyc(1, 5, 0, 0);
        cyc(0, 0, 1, 0);
        idle(9);

        // pause at q=4 for three cycles
        cyc(1, 6, 0, 0);
        cyc(0, 0, 1, 0);
        run_to(4);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        idle(9);

        // reset mid-countdown aborts without done
        cyc(1, 9, 0, 0);
        cyc(0, 0, 1, 0);
        run_to(3);
        async_rst();
        idle(2);
        rn = 1'b1;
        idle(3);
        cyc(0, 0, 1, 0);
        idle(3);

        // zero load never starts; 15 counts without wrap
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 1);
        idle(3);
        cyc(1, 15, 0, 0);
        cyc(0, 0, 1, 0);
        idle(22);

        // load beats start while running
        cyc(1, 9, 0, 0);
        cyc(0, 0, 1, 0);
        run_to(7);
        cyc(1, 2, 1, 0);
        idle(2);
        cyc(0, 0, 1, 0);
        idle(5);

        // reload run, then stopped by loading 0
        cyc(1, 3, 0, 0);
        cyc(0, 0, 1, 0);
        idle(12);
        cyc(1, 0, 0, 0);
        idle(4);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_rst();
                cyc(0, 0, 1, 0);
                rn = 1'b1;
            end else begin
                cyc(($urandom_range(0, 15) == 0),
                    int'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0));
            end
        end
        idle(2);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clock);
        #2;
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset; forces reset state immediately on assertion, independent of clock.
REQ-004 load  input  1  synchronous load strobe.
REQ-005 load_val  input  WIDTH  value captured on load.
REQ-006 start  input  1  begin countdown.
REQ-007 pause  input  1  level; freeze countdown while high.
REQ-008 q  output  WIDTH  registered current count.
REQ-009 busy  output  1  registered; high in RUN or HOLD.
REQ-010 done  output  1  registered; high exactly one cycle when count reaches zero.

Function
REQ-011 The FSM SHALL have four states: IDLE, RUN, HOLD, DONE.
REQ-012 load SHALL have top priority in every state: q <= load_val, next state IDLE, done low; start and pause in that cycle are ignored.
REQ-013 IDLE: q holds; start with q != 0 -> RUN at the next edge; start with q == 0 -> stay IDLE, no done pulse; pause is ignored.
REQ-014 RUN: q <= q - 1 on every edge with pause low; the first decrement occurs one edge after the edge that sampled start.
REQ-015 RUN with pause high: q holds, next state HOLD; HOLD with pause high: q holds; HOLD with pause low: next state RUN, decrement resumes at the following edge.
REQ-016 RUN with q == 1 and pause low: q <= 0, next state DONE.
REQ-017 DONE: done = 1 and q = 0 for one cycle; next state IDLE unconditionally (except load per REQ-012); start in DONE is ignored.
REQ-018 Arithmetic is unsigned modulo 2^WIDTH; q never decrements below 0 (no wrap from 0 to all-ones in any state).
REQ-019 busy = 1 in RUN and HOLD only; done = 1 in DONE only; both are decoded from registered state, not from inputs.

Reset
REQ-020 While reset is low: state IDLE, q = 0, busy = 0, done = 0, reload register = 0.
REQ-021 Reset asserted mid-countdown SHALL abort with no done pulse; after release the block sits in IDLE with q = 0 until load.
REQ-022 Reset deassertion is synchronized externally; the block takes no action on the releasing edge other than normal IDLE behaviour.

Configuration
REQ-023 Macro DOWN_TIMER_AUTO_RELOAD_EN selects auto-reload.
REQ-024 Defined: load_val is also stored in an internal reload register on load; in DONE, q <= reload and next state RUN if reload != 0, else IDLE; done still pulses one cycle; busy stays high through DONE when reloading.
REQ-025 Undefined: no reload register is instantiated; behaviour is exactly REQ-016/REQ-017.

Verification
REQ-026 WIDTH=4, reset low then high, load_val=5 load, start 1 cycle -> q 5,4,3,2,1,0; done high exactly the cycle q=0; busy high for 5 cycles; then IDLE.
REQ-027 load 6, start, pause high 3 cycles when q=4 -> q holds 4 for 3 cycles, busy stays 1, countdown resumes to 0 with one done pulse.
REQ-028 load 9, start, reset low when q=3 -> q=0, busy=0, done=0 immediately (asynchronously); no done pulse after release.
REQ-029 load 0, start -> stays IDLE, busy=0, done never asserts; load 15, start -> 15 decrements, done once, no wrap to 15 afterwards.
REQ-030 While RUN at q=7, assert load with load_val=2 and start together -> q=2, state IDLE, busy=0; a later start counts 2,1,0 with done.
REQ-031 With DOWN_TIMER_AUTO_RELOAD_EN: load 3, start -> q 3,2,1,0,3,2,1,0,... done pulses every 4 cycles, busy remains 1; load 0 then stops in IDLE.
